// File: rtl/uart_rx.sv
// UART receiver: 16x oversampled, 5..8 data bits, optional even/odd parity,
// one or two stop bits. Each frame is delivered as a registered one-clk
// rx_valid pulse together with its data and error flags.
module uart_rx #(
   parameter int unsigned DATA_BITS = 8
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       baud_tick,
   input  logic       rx,
   input  logic       parity_en,
   input  logic       parity_odd,
   input  logic       stop2,
   output logic [7:0] rx_data,
   output logic       rx_valid,
   output logic       parity_err,
   output logic       frame_err,
   output logic       busy
);

   localparam int unsigned TICK_W = 4;
   localparam int unsigned BIT_W  = 3;
   localparam int unsigned BYTE_W = 8;

   // Mid start bit (half a bit time after detection) and mid data/parity/stop bit.
   localparam logic [TICK_W-1:0] MID_START = TICK_W'(7);
   localparam logic [TICK_W-1:0] MID_BIT   = TICK_W'(15);
   localparam logic [BIT_W-1:0]  LAST_BIT  = BIT_W'(DATA_BITS - 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_START,
      S_DATA,
      S_PARITY,
      S_STOP,
      S_WAIT_HIGH
   } state_e;

   // Synchronizer flops
   logic rx_meta_q;
   logic rx_s_q;

   // Frame state
   state_e              state_q,      state_d;
   logic [TICK_W-1:0]   tick_cnt_q,   tick_cnt_d;
   logic [BIT_W-1:0]    bit_cnt_q,    bit_cnt_d;
   logic [BYTE_W-1:0]   shift_q,      shift_d;
   logic                stop_second_q, stop_second_d;
   logic                par_err_q,    par_err_d;
   logic                ferr_q,       ferr_d;

   // Configuration captured at the start of each frame
   logic                cfg_par_en_q,  cfg_par_en_d;
   logic                cfg_par_odd_q, cfg_par_odd_d;
   logic                cfg_stop2_q,   cfg_stop2_d;

   // Output registers
   logic [BYTE_W-1:0]   rx_data_q,    rx_data_d;
   logic                rx_valid_q,   rx_valid_d;
   logic                parity_err_q, parity_err_d;
   logic                frame_err_q,  frame_err_d;
   logic                busy_q,       busy_d;

   // Two-flop synchronizer for the asynchronous serial line (idle high).
   always_ff @(posedge clk) begin
      if (rst) begin
         rx_meta_q <= 1'b1;
         rx_s_q    <= 1'b1;
      end else begin
         rx_meta_q <= rx;
         rx_s_q    <= rx_meta_q;
      end
   end

   // State, counters, captured config and output registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q       <= S_IDLE;
         tick_cnt_q    <= '0;
         bit_cnt_q     <= '0;
         shift_q       <= '0;
         stop_second_q <= 1'b0;
         par_err_q     <= 1'b0;
         ferr_q        <= 1'b0;
         cfg_par_en_q  <= 1'b0;
         cfg_par_odd_q <= 1'b0;
         cfg_stop2_q   <= 1'b0;
         rx_data_q     <= '0;
         rx_valid_q    <= 1'b0;
         parity_err_q  <= 1'b0;
         frame_err_q   <= 1'b0;
         busy_q        <= 1'b0;
      end else begin
         state_q       <= state_d;
         tick_cnt_q    <= tick_cnt_d;
         bit_cnt_q     <= bit_cnt_d;
         shift_q       <= shift_d;
         stop_second_q <= stop_second_d;
         par_err_q     <= par_err_d;
         ferr_q        <= ferr_d;
         cfg_par_en_q  <= cfg_par_en_d;
         cfg_par_odd_q <= cfg_par_odd_d;
         cfg_stop2_q   <= cfg_stop2_d;
         rx_data_q     <= rx_data_d;
         rx_valid_q    <= rx_valid_d;
         parity_err_q  <= parity_err_d;
         frame_err_q   <= frame_err_d;
         busy_q        <= busy_d;
      end
   end

   // Next-state logic: everything advances only on baud ticks; rx_valid is a pulse.
   always_comb begin
      state_d       = state_q;
      tick_cnt_d    = tick_cnt_q;
      bit_cnt_d     = bit_cnt_q;
      shift_d       = shift_q;
      stop_second_d = stop_second_q;
      par_err_d     = par_err_q;
      ferr_d        = ferr_q;
      cfg_par_en_d  = cfg_par_en_q;
      cfg_par_odd_d = cfg_par_odd_q;
      cfg_stop2_d   = cfg_stop2_q;
      rx_data_d     = rx_data_q;
      rx_valid_d    = 1'b0;
      parity_err_d  = parity_err_q;
      frame_err_d   = frame_err_q;

      if (baud_tick) begin
         unique case (state_q)
            S_IDLE: begin
               if (!rx_s_q) begin
                  state_d       = S_START;
                  tick_cnt_d    = '0;
                  bit_cnt_d     = '0;
                  shift_d       = '0;
                  stop_second_d = 1'b0;
                  par_err_d     = 1'b0;
                  ferr_d        = 1'b0;
                  cfg_par_en_d  = parity_en;
                  cfg_par_odd_d = parity_odd;
                  cfg_stop2_d   = stop2;
               end
            end

            S_START: begin
               if (tick_cnt_q == MID_START) begin
                  tick_cnt_d = '0;
                  // A line that is high again at mid start bit was a glitch.
                  state_d    = rx_s_q ? S_IDLE : S_DATA;
               end else begin
                  tick_cnt_d = tick_cnt_q + TICK_W'(1);
               end
            end

            S_DATA: begin
               tick_cnt_d = tick_cnt_q + TICK_W'(1);
               if (tick_cnt_q == MID_BIT) begin
                  shift_d[bit_cnt_q] = rx_s_q;
                  if (bit_cnt_q == LAST_BIT) begin
                     bit_cnt_d = '0;
                     state_d   = cfg_par_en_q ? S_PARITY : S_STOP;
                  end else begin
                     bit_cnt_d = bit_cnt_q + BIT_W'(1);
                  end
               end
            end

            S_PARITY: begin
               tick_cnt_d = tick_cnt_q + TICK_W'(1);
               if (tick_cnt_q == MID_BIT) begin
                  // Unused upper shift bits are zero, so the full-width XOR is exact.
                  par_err_d = (^shift_q) ^ rx_s_q ^ cfg_par_odd_q;
                  state_d   = S_STOP;
               end
            end

            S_STOP: begin
               tick_cnt_d = tick_cnt_q + TICK_W'(1);
               if (tick_cnt_q == MID_BIT) begin
                  if (cfg_stop2_q && !stop_second_q) begin
                     stop_second_d = 1'b1;
                     ferr_d        = ferr_q | ~rx_s_q;
                  end else begin
                     rx_valid_d   = 1'b1;
                     rx_data_d    = shift_q;
                     parity_err_d = cfg_par_en_q & par_err_q;
                     frame_err_d  = ferr_q | ~rx_s_q;
                     ferr_d       = ferr_q | ~rx_s_q;
                     // After a framing error wait for the line to go idle so a
                     // break is not mistaken for a new start bit.
                     state_d      = (ferr_q | ~rx_s_q) ? S_WAIT_HIGH : S_IDLE;
                  end
               end
            end

            S_WAIT_HIGH: begin
               if (rx_s_q) begin
                  state_d = S_IDLE;
               end
            end

            default: begin
               state_d = S_IDLE;
            end
         endcase
      end

      busy_d = (state_d != S_IDLE);
   end

   assign rx_data    = rx_data_q;
   assign rx_valid   = rx_valid_q;
   assign parity_err = parity_err_q;
   assign frame_err  = frame_err_q;
   assign busy       = busy_q;

endmodule

// File: tb/tb_uart_rx.sv
// Bench for uart_rx: an 8-bit and a 7-bit receiver share clock, baud tick,
// reset and config; serial frames are built from data and flags, expected
// results are queued per receiver and checked by independent monitors.
module tb_uart_rx;

   typedef struct packed {
      logic [7:0] data;
      logic       perr;
      logic       ferr;
   } exp_t;

   logic       clk = 1'b0;
   logic       rst;
   logic       baud_tick;
   logic       parity_en, parity_odd, stop2;
   logic       rx8, rx7;
   logic [7:0] d8, d7;
   logic       v8, v7, pe8, pe7, fe8, fe7, b8, b7;

   exp_t        q8[$];
   exp_t        q7[$];
   exp_t        last8, last7;
   logic        pv8, pv7;
   int unsigned n_chk = 0;
   int unsigned n_err = 0;

   uart_rx #(.DATA_BITS(8)) dut8 (
      .clk(clk), .rst(rst), .baud_tick(baud_tick), .rx(rx8),
      .parity_en(parity_en), .parity_odd(parity_odd), .stop2(stop2),
      .rx_data(d8), .rx_valid(v8), .parity_err(pe8), .frame_err(fe8), .busy(b8)
   );

   uart_rx #(.DATA_BITS(7)) dut7 (
      .clk(clk), .rst(rst), .baud_tick(baud_tick), .rx(rx7),
      .parity_en(parity_en), .parity_odd(parity_odd), .stop2(stop2),
      .rx_data(d7), .rx_valid(v7), .parity_err(pe7), .frame_err(fe7), .busy(b7)
   );

   always #5 clk = ~clk;

   // Baud tick: one clk in four, changing on the falling edge.
   initial begin
      baud_tick = 1'b0;
      forever begin
         repeat (3) @(negedge clk);
         baud_tick = 1'b1;
         @(negedge clk);
         baud_tick = 1'b0;
      end
   end

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation time limit reached, errors=%0d", n_err);
      $fatal(1, "watchdog");
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic wait_ticks(input int n);
      repeat (n) begin
         @(posedge clk);
         while (baud_tick !== 1'b1) @(posedge clk);
      end
   endtask

   // Hold one line level for n baud ticks.
   task automatic drive_bit(input logic sel, input logic val, input int n);
      @(negedge clk);
      if (sel) rx7 = val;
      else     rx8 = val;
      wait_ticks(n);
   endtask

   // Send a frame: start, data LSB first, optional parity, stop bit(s).
   // stop_bad[0]/[1] drive the first/second stop bit low; flip corrupts parity.
   task automatic send_frame(input logic sel, input logic [7:0] data, input logic pen,
                             input logic odd, input logic st2, input logic flip,
                             input logic [1:0] stop_bad);
      int         nb;
      logic [7:0] dm;
      logic       pbit;
      exp_t       e;
      nb   = sel ? 7 : 8;
      dm   = sel ? (data & 8'h7F) : data;
      pbit = (^dm) ^ odd ^ flip;
      e.data = dm;
      e.perr = pen & flip;
      e.ferr = stop_bad[0] | (st2 & stop_bad[1]);
      @(negedge clk);
      parity_en  = pen;
      parity_odd = odd;
      stop2      = st2;
      if (sel) q7.push_back(e);
      else     q8.push_back(e);
      drive_bit(sel, 1'b0, 16);
      // Config changes after the start bit must not affect this frame.
      parity_en  = 1'($urandom);
      parity_odd = 1'($urandom);
      stop2      = 1'($urandom);
      for (int i = 0; i < nb; i++) drive_bit(sel, dm[i], 16);
      if (pen) drive_bit(sel, pbit, 16);
      drive_bit(sel, ~stop_bad[0], 16);
      if (st2) drive_bit(sel, ~stop_bad[1], 16);
   endtask

   // Monitor for the 8-bit receiver.
   always begin
      exp_t e;
      @(posedge clk);
      #1;
      if (rst) begin
         last8 = '0;
         pv8   = 1'b0;
      end else begin
         if (v8) begin
            check("valid8_single_pulse", 32'(pv8), 32'd0);
            if (q8.size() == 0) begin
               n_chk++;
               n_err++;
               $display("FAIL valid8_unexpected: rx_valid with no frame pending, data=0x%0h", d8);
            end else begin
               e = q8.pop_front();
               check("data8", 32'(d8), 32'(e.data));
               check("perr8", 32'(pe8), 32'(e.perr));
               check("ferr8", 32'(fe8), 32'(e.ferr));
               last8 = e;
            end
         end else begin
            check("hold8", 32'({d8, pe8, fe8}), 32'(last8));
         end
         pv8 = v8;
      end
   end

   // Monitor for the 7-bit receiver.
   always begin
      exp_t e;
      @(posedge clk);
      #1;
      if (rst) begin
         last7 = '0;
         pv7   = 1'b0;
      end else begin
         if (v7) begin
            check("valid7_single_pulse", 32'(pv7), 32'd0);
            if (q7.size() == 0) begin
               n_chk++;
               n_err++;
               $display("FAIL valid7_unexpected: rx_valid with no frame pending, data=0x%0h", d7);
            end else begin
               e = q7.pop_front();
               check("data7", 32'(d7), 32'(e.data));
               check("perr7", 32'(pe7), 32'(e.perr));
               check("ferr7", 32'(fe7), 32'(e.ferr));
               last7 = e;
            end
         end else begin
            check("hold7", 32'({d7, pe7, fe7}), 32'(last7));
         end
         pv7 = v7;
      end
   end

   initial begin
      rst        = 1'b1;
      rx8        = 1'b1;
      rx7        = 1'b1;
      parity_en  = 1'b0;
      parity_odd = 1'b0;
      stop2      = 1'b0;
      repeat (3) @(negedge clk);
      check("rst_data8",  32'(d8),  32'd0);
      check("rst_valid8", 32'(v8),  32'd0);
      check("rst_perr8",  32'(pe8), 32'd0);
      check("rst_ferr8",  32'(fe8), 32'd0);
      check("rst_busy8",  32'(b8),  32'd0);
      check("rst_data7",  32'(d7),  32'd0);
      check("rst_busy7",  32'(b7),  32'd0);
      rst = 1'b0;
      drive_bit(1'b0, 1'b1, 8);

      // 8N1 0x55
      send_frame(1'b0, 8'h55, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00);
      drive_bit(1'b0, 1'b1, 16);
      @(negedge clk);
      check("busy8_after_55", 32'(b8), 32'd0);

      // 8E1 0xA3, correct then corrupted parity
      send_frame(1'b0, 8'hA3, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00);
      send_frame(1'b0, 8'hA3, 1'b1, 1'b0, 1'b0, 1'b1, 2'b00);
      drive_bit(1'b0, 1'b1, 8);

      // 8N1 0x3C with a low stop bit, line held low (break)
      send_frame(1'b0, 8'h3C, 1'b0, 1'b0, 1'b0, 1'b0, 2'b01);
      drive_bit(1'b0, 1'b0, 40);
      @(negedge clk);
      check("busy8_in_break", 32'(b8), 32'd1);
      drive_bit(1'b0, 1'b1, 16);
      @(negedge clk);
      check("busy8_after_break", 32'(b8), 32'd0);

      // False start: low for 4 ticks only
      drive_bit(1'b0, 1'b0, 4);
      @(negedge clk);
      check("busy8_false_start", 32'(b8), 32'd1);
      drive_bit(1'b0, 1'b1, 12);
      @(negedge clk);
      check("busy8_false_start_end", 32'(b8), 32'd0);

      // Reset in the middle of bit 3 of a frame
      parity_en = 1'b0;
      stop2     = 1'b0;
      drive_bit(1'b0, 1'b0, 16);
      drive_bit(1'b0, 1'b1, 16);
      drive_bit(1'b0, 1'b0, 16);
      drive_bit(1'b0, 1'b0, 16);
      drive_bit(1'b0, 1'b0, 8);
      @(negedge clk);
      rst = 1'b1;
      rx8 = 1'b1;
      @(negedge clk);
      check("midrst_data8",  32'(d8),  32'd0);
      check("midrst_valid8", 32'(v8),  32'd0);
      check("midrst_perr8",  32'(pe8), 32'd0);
      check("midrst_ferr8",  32'(fe8), 32'd0);
      check("midrst_busy8",  32'(b8),  32'd0);
      rst = 1'b0;
      drive_bit(1'b0, 1'b1, 32);
      send_frame(1'b0, 8'h81, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00);
      drive_bit(1'b0, 1'b1, 8);

      // 7O2 0x7F twice back to back on the 7-bit receiver
      send_frame(1'b1, 8'h7F, 1'b1, 1'b1, 1'b1, 1'b0, 2'b00);
      send_frame(1'b1, 8'h7F, 1'b1, 1'b1, 1'b1, 1'b0, 2'b00);
      drive_bit(1'b1, 1'b1, 8);

      // Randomized frames on both receivers
      for (int k = 0; k < 24; k++) begin
         logic       s, pen, odd, st2, fl;
         logic [7:0] d;
         logic [1:0] sb;
         s   = 1'($urandom_range(0, 3) == 0);
         d   = 8'($urandom);
         pen = 1'($urandom);
         odd = 1'($urandom);
         st2 = 1'($urandom);
         fl  = 1'($urandom_range(0, 3) == 0);
         sb  = ($urandom_range(0, 5) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
         send_frame(s, d, pen, odd, st2, fl, sb);
         drive_bit(s, 1'b1, (sb != 2'b00 || $urandom_range(0, 2) == 0) ? 20 : 0);
      end

      drive_bit(1'b0, 1'b1, 48);
      @(negedge clk);
      check("drained8", 32'(q8.size()), 32'd0);
      check("drained7", 32'(q7.size()), 32'd0);
      check("idle_busy8", 32'(b8), 32'd0);
      check("idle_busy7", 32'(b7), 32'd0);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
